eq_burst_checker: RTL and testbench
===================================

// Module: eq_burst_checker
// PURPOSE
//  Downstream consumer of the equality-operator stage. Accepts a burst of BURST_LEN
//  operand pairs (A,B) over a valid/ready stream and classifies each pair:
//  logical == (0/1/unknown) and case === (0/1).
//  Emits a registered per-beat result stream and keeps per-burst match/mismatch/unknown
//  counters, with a done pulse at burst end. Used as a simulation-side scoreboard stage.
// PARAMETERS
//  WIDTH      4   operand width in bits
//  BURST_LEN  8   operand pairs accepted per burst (1..2**CNT_W-1)
//  CNT_W      8   width of each summary counter
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  rst_n        in   1      synchronous, active-low reset
//  start        in   1      pulse: begin new burst (honoured in IDLE only)
//  in_valid     in   1      operand pair valid
//  in_ready     out  1      checker can accept a pair
//  A            in   WIDTH  operand A (may carry x/z in simulation)
//  B            in   WIDTH  operand B
//  res_valid    out  1      per-beat result valid
//  res_ready    in   1      downstream accepts result
//  res_eq       out  1      1 iff (A==B) evaluated to 1'b1
//  res_unknown  out  1      1 iff (A==B) evaluated to x
//  res_case_eq  out  1      value of (A===B)
//  match_cnt    out  CNT_W  beats with res_eq=1 in current/last burst
//  mismatch_cnt out  CNT_W  beats where (A==B)===1'b0
//  unknown_cnt  out  CNT_W  beats with res_unknown=1
//  done         out  1      one-cycle pulse: burst complete, counters final
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; in_ready, res_valid, res_*, done, all counters,
//  beat counter = 0. Reset mid-burst abandons the burst; no done pulse.
//  FSM: IDLE -start-> RUN (same edge clears the three counters and the beat counter).
//    RUN: accept beats; the BURST_LEN-th accepted beat -> DRAIN.
//    DRAIN: wait until res_valid=0 or (res_valid & res_ready); then done=1 for one cycle,
//    -> IDLE. start in RUN/DRAIN is ignored.
//  in_ready = (state==RUN) & (~res_valid | res_ready); combinational, no in_valid dependency.
//  Accept = in_valid & in_ready. Result registered: res_* valid on the cycle after accept
//  (latency 1); res_* held stable while res_valid & ~res_ready. Full throughput 1 beat/cycle.
//  res_valid clears when accepted with no new beat in the same cycle.
//  Classification per beat (exactly one of match/mismatch/unknown increments, same edge as accept):
//    (A==B)===1'b1 -> match; (A==B)===1'b0 -> mismatch; else unknown.
//    res_case_eq independent: e.g. A=B=4'bxx01 -> unknown, case_eq=1.
//  Counters saturate at 2**CNT_W-1; they hold their values in IDLE until the next start.
//  Synthesis: x never observed, so unknown_cnt stays 0 and res_case_eq==res_eq.
// STRUCTURE
//  package eq_pkg: localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2;
//    class codes CLS_MATCH=2'd0, CLS_MISM=2'd1, CLS_UNK=2'd2.
//  Sub-module eq_classify (combinational): A,B -> cls[1:0], case_eq. Instanced once.
//  Top holds the FSM, beat counter ($clog2(BURST_LEN+1) bits), result register and counters.
// TESTING
//  1 Reset: rst_n=0 two cycles mid-RUN -> all outputs 0, state IDLE, no done.
//  2 Known operands: start; A=4'b0101,B=4'b0101 then A=4'b0101,B=4'b0110 ->
//    res (eq,unk,ceq)=(1,0,1) then (0,0,0); match_cnt=1, mismatch_cnt=1.
//  3 X operands: A=4'bx001,B=4'bx101 -> (0,0,0) mismatch;
//    A=4'bxx01,B=4'bxx01 -> (0,1,1), unknown_cnt=1.
//  4 Backpressure: res_ready=0 for 3 cycles with in_valid=1 -> in_ready=0;
//    res_* held stable; no beat lost or duplicated.
//  5 Burst end: BURST_LEN=8 beats back-to-back -> done pulses exactly once, after the last
//    result handshake; start during RUN ignored; counts sum to 8.
//  6 Saturation: CNT_W=2, BURST_LEN=3, all-match burst, then a second burst with 3 matches ->
//    match_cnt=3 each burst (cleared at start, no wrap).

Source files
------------

// File: rtl/eq_pkg.sv
// Shared FSM state codes and per-beat classification codes for the equality burst checker.
package eq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] CLS_MATCH = 2'd0;
  localparam logic [1:0] CLS_MISM  = 2'd1;
  localparam logic [1:0] CLS_UNK   = 2'd2;

endpackage

// File: rtl/eq_classify.sv
// Combinational classifier: logical equality as match/mismatch/unknown plus case equality.
module eq_classify
  import eq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       cls,
  output logic             case_eq
);

  logic eq_w;

  // x/z on either operand can make == evaluate to x; hardware never sees that case
  always_comb begin
    eq_w    = (a == b);
    case_eq = (a === b);
    if (eq_w === 1'b1) begin
      cls = CLS_MATCH;
    end else if (eq_w === 1'b0) begin
      cls = CLS_MISM;
    end else begin
      cls = CLS_UNK;
    end
  end

endmodule

// File: rtl/eq_burst_checker.sv
// Burst equality checker: classifies BURST_LEN operand pairs, registers per-beat results
// and keeps saturating per-burst match/mismatch/unknown counters with a done pulse.
module eq_burst_checker
  import eq_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_eq,
  output logic             res_unknown,
  output logic             res_case_eq,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] unknown_cnt,
  output logic             done
);

  localparam int              BEAT_W    = $clog2(BURST_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [1:0]        state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [1:0]        cls_p0;
  logic              ceq_p0;
  logic              accept;
  logic              drain_ok;
  logic              vld_p1;
  logic              eq_p1;
  logic              unk_p1;
  logic              ceq_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  eq_classify #(
    .WIDTH (WIDTH)
  ) u_classify (
    .a       (A),
    .b       (B),
    .cls     (cls_p0),
    .case_eq (ceq_p0)
  );

  assign in_ready = (state == ST_RUN) && (!vld_p1 || res_ready);
  assign accept   = in_valid && in_ready;
  assign drain_ok = !vld_p1 || res_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      done         <= 1'b0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      unknown_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_RUN;
            beat_cnt     <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            unknown_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              state <= ST_DRAIN;
            end
            case (cls_p0)
              CLS_MATCH: match_cnt    <= sat_inc(match_cnt);
              CLS_MISM:  mismatch_cnt <= sat_inc(mismatch_cnt);
              default:   unknown_cnt  <= sat_inc(unknown_cnt);
            endcase
          end
        end
        ST_DRAIN: begin
          // done waits for the last result to leave the output register
          if (drain_ok) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // p0 -> p1: classified beat captured into the result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      eq_p1  <= 1'b0;
      unk_p1 <= 1'b0;
      ceq_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      eq_p1  <= (cls_p0 == CLS_MATCH);
      unk_p1 <= (cls_p0 == CLS_UNK);
      ceq_p1 <= ceq_p0;
    end else if (res_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign res_valid   = vld_p1;
  assign res_eq      = eq_p1;
  assign res_unknown = unk_p1;
  assign res_case_eq = ceq_p1;

endmodule

// File: tb/tb_eq_burst_checker.sv
// Self-checking bench: behavioural burst model compared every cycle, plus directed literal checks.
module tb_eq_burst_checker;

  localparam int WIDTH = 4;
  localparam int BL    = 8;
  localparam int CW    = 8;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, res_ready;
  logic [WIDTH-1:0] a, b;
  logic in_ready, res_valid, res_eq, res_unknown, res_case_eq, done;
  logic [CW-1:0] match_cnt, mismatch_cnt, unknown_cnt;

  logic s_start, s_in_valid, s_res_ready;
  logic [3:0] s_a, s_b;
  logic s_in_ready, s_res_valid, s_res_eq, s_res_unknown, s_res_case_eq, s_done;
  logic [1:0] s_match, s_mism, s_unk;

  int checks = 0;
  int failures = 0;
  int dn_cnt = 0;
  int dn0;
  bit four_state;
  logic probe;
  logic [2:0] hv;

  // behavioural model state
  int   m_phase;  // 0 idle, 1 collecting beats, 2 waiting for last result to drain
  int   m_beats, m_match, m_mism, m_unkc;
  logic m_rv, m_eq, m_unk, m_ceq, m_done;
  logic m_rdy, m_acc, m_w;

  always #5 clk = ~clk;

  eq_burst_checker #(.WIDTH(WIDTH), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .res_valid(res_valid), .res_ready(res_ready), .res_eq(res_eq),
    .res_unknown(res_unknown), .res_case_eq(res_case_eq), .match_cnt(match_cnt),
    .mismatch_cnt(mismatch_cnt), .unknown_cnt(unknown_cnt), .done(done)
  );

  eq_burst_checker #(.WIDTH(4), .BURST_LEN(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .A(s_a), .B(s_b), .res_valid(s_res_valid), .res_ready(s_res_ready), .res_eq(s_res_eq),
    .res_unknown(s_res_unknown), .res_case_eq(s_res_case_eq), .match_cnt(s_match),
    .mismatch_cnt(s_mism), .unknown_cnt(s_unk), .done(s_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // model advances on each rising edge from the same inputs the DUT samples
  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_beats = 0; m_match = 0; m_mism = 0; m_unkc = 0;
      m_rv = 0; m_eq = 0; m_unk = 0; m_ceq = 0; m_done = 0;
    end else begin
      m_rdy  = (m_phase == 1) && (!m_rv || res_ready);
      m_acc  = in_valid && m_rdy;
      m_done = 0;
      if (m_phase == 0 && start) begin
        m_phase = 1; m_beats = 0; m_match = 0; m_mism = 0; m_unkc = 0;
      end else if (m_phase == 1 && m_acc) begin
        m_beats++;
        if (m_beats == BL) m_phase = 2;
      end else if (m_phase == 2 && (!m_rv || res_ready)) begin
        m_done  = 1;
        m_phase = 0;
      end
      if (m_acc) begin
        m_w   = (a == b);
        m_ceq = (a === b);
        m_eq  = (m_w === 1'b1);
        m_unk = (m_w !== 1'b1) && (m_w !== 1'b0);
        if (m_eq) begin
          if (m_match < (2**CW - 1)) m_match++;
        end else if (m_unk) begin
          if (m_unkc < (2**CW - 1)) m_unkc++;
        end else begin
          if (m_mism < (2**CW - 1)) m_mism++;
        end
        m_rv = 1;
      end else if (res_ready) begin
        m_rv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) dn_cnt++;
    if (rst_n) begin
      chk("in_ready", in_ready, (m_phase == 1) && (!m_rv || res_ready));
      chk("res_valid", res_valid, m_rv);
      chk("done", done, m_done);
      chk("match_cnt", match_cnt, m_match);
      chk("mismatch_cnt", mismatch_cnt, m_mism);
      chk("unknown_cnt", unknown_cnt, m_unkc);
      if (m_rv) chk("res_bits", {res_eq, res_unknown, res_case_eq}, {m_eq, m_unk, m_ceq});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    probe = 1'bx;
    four_state = $isunknown(probe);
    rst_n = 0; start = 0; in_valid = 0; res_ready = 1; a = '0; b = '0;
    s_start = 0; s_in_valid = 0; s_res_ready = 1; s_a = '0; s_b = '0;
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_counts", {match_cnt, mismatch_cnt, unknown_cnt}, 0);
    #1 rst_n = 1;
    step();

    // directed burst: known operands, x operands, backpressure, ignored start, done
    dn0 = dn_cnt;
    start = 1; step(); start = 0;
    res_ready = 1; in_valid = 1; a = 4'b0101; b = 4'b0101; step();
    @(negedge clk);
    chk("beat1_res", {res_eq, res_unknown, res_case_eq}, 3'b101);
    #1 a = 4'b0101; b = 4'b0110; step();
    @(negedge clk);
    chk("beat2_res", {res_eq, res_unknown, res_case_eq}, 3'b000);
    chk("beat2_match", match_cnt, 1);
    chk("beat2_mism", mismatch_cnt, 1);
    #1 a = 4'bx001; b = 4'bx101; step();
    @(negedge clk);
    chk("beat3_res", {res_eq, res_unknown, res_case_eq}, 3'b000);
    chk("beat3_mism", mismatch_cnt, 2);
    #1 a = 4'bxx01; b = 4'bxx01; step();
    @(negedge clk);
    if (four_state) begin
      chk("beat4_res", {res_eq, res_unknown, res_case_eq}, 3'b011);
      chk("beat4_unk", unknown_cnt, 1);
    end
    hv = {res_eq, res_unknown, res_case_eq};
    #1 a = 4'b0011; b = 4'b0011; res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", res_valid, 1);
      chk("stall_hold", {res_eq, res_unknown, res_case_eq}, hv);
    end
    #1 res_ready = 1; start = 1; step();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      a = 4'($urandom); b = (i == 1) ? a : 4'($urandom); step();
    end
    in_valid = 0;
    for (int i = 0; i < 10 && !m_done; i++) step();
    chk("burst_done_seen", m_done, 1);
    repeat (3) step();
    chk("done_once", dn_cnt - dn0, 1);
    chk("burst_sum", 32'(match_cnt) + 32'(mismatch_cnt) + 32'(unknown_cnt), BL);

    // reset in the middle of a burst
    dn0 = dn_cnt;
    start = 1; step(); start = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      a = 4'($urandom); b = a; step();
    end
    rst_n = 0; in_valid = 0;
    step(); step();
    @(negedge clk);
    chk("mrst_outs", {in_ready, res_valid, res_eq, res_unknown, res_case_eq, done}, 0);
    chk("mrst_counts", {match_cnt, mismatch_cnt, unknown_cnt}, 0);
    #1 rst_n = 1;
    repeat (4) step();
    @(negedge clk);
    chk("mrst_no_done", dn_cnt - dn0, 0);
    chk("mrst_idle", in_ready, 0);
    #1;

    // randomized bursts with random valid/ready and stray start pulses
    for (int k = 0; k < 8; k++) begin
      start = 1; step(); start = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        res_ready = ($urandom_range(0, 3) != 0);
        a = 4'($urandom);
        b = $urandom_range(0, 1) ? a : 4'($urandom);
        start = ($urandom_range(0, 15) == 0);
        step();
        if (m_done) break;
      end
      chk("rand_burst_done", m_done, 1);
      start = 0; in_valid = 0; res_ready = 1;
      step();
    end

    // small-counter instance: counters cleared at start, reach 3 without wrapping
    for (int k = 0; k < 2; k++) begin
      s_start = 1; step(); s_start = 0;
      @(negedge clk);
      chk("sat_cleared", s_match, 0);
      #1 s_in_valid = 1; s_res_ready = 1;
      for (int j = 0; j < 3; j++) begin
        s_a = 4'($urandom); s_b = s_a; step();
      end
      s_in_valid = 0;
      for (int i = 0; i < 10 && !s_done; i++) @(negedge clk);
      chk("sat_done", s_done, 1);
      chk("sat_match", s_match, 3);
      chk("sat_other", {s_mism, s_unk}, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
